// File: rtl/hit_sensor_scanner.sv
// Hit sensor scanner: synchronises four raw mole-box sensors, debounces them, arbitrates
// simultaneous strikes and emits one registered hit strobe per physical strike.
module hit_sensor_scanner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int LOCKOUT_CYCLES  = 5000000,
    parameter int CNT_W           = 23
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [3:0] sensor_raw,
    output logic       hit_detected,
    output logic [1:0] sensor_input,
    output logic       multi_hit,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE,
        DEBOUNCE,
        REPORT,
        LOCKOUT,
        WAIT_RELEASE
    } state_t;

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCKOUT_CYCLES - 1);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [1:0]       cand_reg, cand_next;
    logic [3:0]       s1_reg, s2_reg;
    logic             hit_detected_reg;
    logic [1:0]       sensor_input_reg;
    logic             multi_hit_reg;
    logic             busy_reg;

    logic [1:0]       lowest_idx;
    logic [3:0]       cand_onehot;
    logic             multi_next;

    // Fixed priority: box 0 beats 1 beats 2 beats 3.
    always_comb begin
        lowest_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (s2_reg[i]) begin
                lowest_idx = 2'(i);
            end
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_onehot
            assign cand_onehot[gi] = (cand_reg == 2'(gi));
        end
    endgenerate

    // s1 is what s2 will hold during the REPORT cycle, so the flag reflects
    // the sensors exactly while the strobe is high.
    assign multi_next = |(s1_reg & ~cand_onehot);

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        cand_next  = cand_reg;
        case (state_reg)
            IDLE: begin
                if (enable && (|s2_reg)) begin
                    cand_next  = lowest_idx;
                    cnt_next   = '0;
                    state_next = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (!enable || !s2_reg[cand_reg]) begin
                    state_next = IDLE;
                end else if (cnt_reg == DEB_LAST) begin
                    state_next = REPORT;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            REPORT: begin
                cnt_next   = '0;
                state_next = LOCKOUT;
            end
            LOCKOUT: begin
                if (!enable) begin
                    state_next = IDLE;
                end else if (cnt_reg == LOCK_LAST) begin
                    state_next = WAIT_RELEASE;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            WAIT_RELEASE: begin
                if (!enable || (s2_reg == 4'b0000)) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg        <= IDLE;
            cnt_reg          <= '0;
            cand_reg         <= 2'd0;
            s1_reg           <= 4'b0000;
            s2_reg           <= 4'b0000;
            hit_detected_reg <= 1'b0;
            sensor_input_reg <= 2'd0;
            multi_hit_reg    <= 1'b0;
            busy_reg         <= 1'b0;
        end else begin
            s1_reg           <= sensor_raw;
            s2_reg           <= s1_reg;
            state_reg        <= state_next;
            cnt_reg          <= cnt_next;
            cand_reg         <= cand_next;
            busy_reg         <= (state_next != IDLE);
            hit_detected_reg <= (state_next == REPORT);
            if (state_next == REPORT) begin
                sensor_input_reg <= cand_reg;
                multi_hit_reg    <= multi_next;
            end else begin
                multi_hit_reg    <= 1'b0;
            end
        end
    end

    assign hit_detected = hit_detected_reg;
    assign sensor_input = sensor_input_reg;
    assign multi_hit    = multi_hit_reg;
    assign busy         = busy_reg;

endmodule

// File: tb/tb_hit_sensor_scanner.sv
// Scoreboard bench for hit_sensor_scanner: stimulus queues expected strobes, a monitor
// matches every observed strobe (cycle, box index, multi flag) against the queue.
module tb_hit_sensor_scanner;

    localparam int DEB = 4;
    localparam int LOCK = 8;
    localparam int CW = 4;
    localparam int LAT = DEB + 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b1;
    logic [3:0] sensor_raw = 4'b0000;
    logic       hit_detected;
    logic [1:0] sensor_input;
    logic       multi_hit;
    logic       busy;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc_cnt = 0;
    int c0;

    typedef struct {
        int         cyc;
        logic [1:0] idx;
        logic       multi;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    hit_sensor_scanner #(
        .DEBOUNCE_CYCLES(DEB),
        .LOCKOUT_CYCLES (LOCK),
        .CNT_W          (CW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .sensor_raw  (sensor_raw),
        .hit_detected(hit_detected),
        .sensor_input(sensor_input),
        .multi_hit   (multi_hit),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Monitor: every strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (hit_detected) begin
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL unexpected_strobe: cycle %0d idx %0d multi %0b, required no strobe",
                         cyc_cnt, sensor_input, multi_hit);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.cyc != cyc_cnt || mon_e.idx != sensor_input || mon_e.multi != multi_hit) begin
                    tests_failed++;
                    $display("FAIL strobe: got cyc=%0d idx=%0d multi=%0b, required cyc=%0d idx=%0d multi=%0b",
                             cyc_cnt, sensor_input, multi_hit, mon_e.cyc, mon_e.idx, mon_e.multi);
                end else begin
                    $display("[TB] strobe cyc=%0d idx=%0d multi=%0b ok", cyc_cnt, sensor_input, multi_hit);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int got, input int want);
        tests_run++;
        if (got != want) begin
            tests_failed++;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end else begin
            $display("[TB] %s = %0d ok", name, got);
        end
    endtask

    task automatic expect_hit(input int cyc, input logic [1:0] idx, input logic multi);
        exp_t e;
        e.cyc   = cyc;
        e.idx   = idx;
        e.multi = multi;
        exp_q.push_back(e);
    endtask

    initial begin
        tick(2);
        check("reset_hit", int'(hit_detected), 0);
        check("reset_idx", int'(sensor_input), 0);
        check("reset_multi", int'(multi_hit), 0);
        check("reset_busy", int'(busy), 0);
        reset = 1'b0;
        tick(3);

        // Short glitch on box 1: debounce starts then aborts.
        sensor_raw = 4'b0010;
        tick(3);
        sensor_raw = 4'b0000;
        tick(1);
        check("glitch_busy_rise", int'(busy), 1);
        tick(8);
        check("glitch_busy_fall", int'(busy), 0);
        check("glitch_idx_kept", int'(sensor_input), 0);

        // Clean strike on box 2.
        c0 = cyc_cnt;
        expect_hit(c0 + LAT, 2'd2, 1'b0);
        sensor_raw = 4'b0100;
        tick(20);
        sensor_raw = 4'b0000;
        tick(12);
        check("box2_idle", int'(busy), 0);
        check("box2_idx_held", int'(sensor_input), 2);

        // Boxes 3 and 0 together: box 0 wins, multi flagged.
        c0 = cyc_cnt;
        expect_hit(c0 + LAT, 2'd0, 1'b1);
        sensor_raw = 4'b1001;
        tick(20);
        sensor_raw = 4'b0000;
        tick(12);

        // Long hold yields one strobe; re-strike after release yields another.
        c0 = cyc_cnt;
        expect_hit(c0 + LAT, 2'd1, 1'b0);
        sensor_raw = 4'b0010;
        tick(100);
        check("hold_wait_busy", int'(busy), 1);
        sensor_raw = 4'b0000;
        tick(5);
        c0 = cyc_cnt;
        expect_hit(c0 + LAT, 2'd1, 1'b0);
        sensor_raw = 4'b0010;
        tick(10);
        sensor_raw = 4'b0000;
        tick(12);

        // Lockout length: strike box 3, release right after the strobe.
        c0 = cyc_cnt;
        expect_hit(c0 + LAT, 2'd3, 1'b0);
        sensor_raw = 4'b1000;
        tick(8);
        sensor_raw = 4'b0000;
        tick(8);
        check("lockout_end_busy", int'(busy), 1);
        tick(1);
        check("lockout_release_idle", int'(busy), 0);
        tick(4);

        // Disabled scanning never arms.
        enable = 1'b0;
        sensor_raw = 4'b0010;
        tick(3);
        check("disabled_busy", int'(busy), 0);
        tick(17);
        sensor_raw = 4'b0000;
        tick(4);
        enable = 1'b1;
        tick(2);

        // Enable dropped mid-debounce aborts next edge.
        sensor_raw = 4'b0010;
        tick(4);
        check("drop_en_busy", int'(busy), 1);
        enable = 1'b0;
        tick(1);
        check("drop_en_idle", int'(busy), 0);
        tick(6);
        check("drop_en_still_idle", int'(busy), 0);
        sensor_raw = 4'b0000;
        tick(4);
        enable = 1'b1;
        tick(4);

        // Asynchronous reset mid-debounce, sensor kept high.
        sensor_raw = 4'b0001;
        tick(4);
        reset = 1'b1;
        #1;
        check("midrst_hit", int'(hit_detected), 0);
        check("midrst_idx", int'(sensor_input), 0);
        check("midrst_multi", int'(multi_hit), 0);
        check("midrst_busy", int'(busy), 0);
        tick(1);
        reset = 1'b0;
        c0 = cyc_cnt;
        expect_hit(c0 + LAT, 2'd0, 1'b0);
        tick(20);
        sensor_raw = 4'b0000;
        tick(12);

        check("pending_strobes", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
